// File: rtl/fft_ctrl_param.sv
// Frame sequencer for the FFT butterfly core: walks one frame of FRAME_LEN ticks per
// s_p fill and drives mux/demux selects, the twiddle index, frame status and overrun.
module fft_ctrl_param #(
  parameter int FRAME_LEN = 8,
  parameter int LOAD_LEN  = 4,
  parameter int ROT_W     = 3,
  parameter int ROT_STEP  = 1,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_p_flag_in,
  input  logic              en,
  input  logic              inv_in,
  input  logic              clr_err,
  output logic              mux_flag,
  output logic              demux_flag,
  output logic [ROT_W-1:0]  rotation,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overrun
);

  localparam int TICK_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [TICK_W-1:0] LAST = TICK_W'(FRAME_LEN - 1);
  localparam logic [TICK_W-1:0] LOAD = TICK_W'(LOAD_LEN);

  logic [TICK_W-1:0] tick;
  logic              inv_q;

  // Twiddle index: k = tick*ROT_STEP wrapped to ROT_W bits, negated modulo 2^ROT_W for IFFT.
  function automatic logic [ROT_W-1:0] twiddle_idx(input logic [TICK_W-1:0] t,
                                                   input logic neg);
    logic [ROT_W-1:0] k;
    k = ROT_W'(32'(t) * 32'(ROT_STEP));
    return neg ? (ROT_W'(0) - k) : k;
  endfunction

  // Tick sequencing; a held start request on the idle tick chains frames without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick  <= '0;
      inv_q <= 1'b0;
    end else if (en) begin
      if (tick == '0) begin
        if (s_p_flag_in) begin
          tick  <= TICK_W'(1);
          inv_q <= inv_in;
        end
      end else if (tick == LAST) begin
        tick <= '0;
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

  // Registered outputs, one cycle behind tick; frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_flag   <= 1'b0;
      demux_flag <= 1'b0;
      rotation   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (en) begin
      mux_flag   <= (tick >= LOAD);
      demux_flag <= (tick < LOAD);
      rotation   <= twiddle_idx(tick, inv_q);
      busy       <= (tick != '0);
      frame_done <= (tick == LAST);
      if (tick == LAST) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

  // Overrun watches requests even during a stall; a new set beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (s_p_flag_in && (tick != '0) && (tick != LAST)) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_ctrl_param.sv
// Directed bench for fft_ctrl_param: default 8-tick instance plus a 16-tick,
// step-2 instance, checked each cycle against hand-derived sequences.
module tb_fft_ctrl_param;

  logic       clk = 1'b0;
  logic       rst, sp, inv, en, clr;
  logic       mux, demux, busy, fd, ovr;
  logic [2:0] rot;
  logic [7:0] cnt;

  logic       sp2, en2, inv2, clr2;
  logic       mux2, demux2, busy2, fd2, ovr2;
  logic [3:0] rot2;
  logic [7:0] cnt2;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fft_ctrl_param u_dut (
    .clk(clk), .rst(rst), .s_p_flag_in(sp), .en(en), .inv_in(inv), .clr_err(clr),
    .mux_flag(mux), .demux_flag(demux), .rotation(rot), .busy(busy),
    .frame_done(fd), .frame_cnt(cnt), .overrun(ovr)
  );

  fft_ctrl_param #(.FRAME_LEN(16), .LOAD_LEN(5), .ROT_W(4), .ROT_STEP(2), .FCNT_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .s_p_flag_in(sp2), .en(en2), .inv_in(inv2), .clr_err(clr2),
    .mux_flag(mux2), .demux_flag(demux2), .rotation(rot2), .busy(busy2),
    .frame_done(fd2), .frame_cnt(cnt2), .overrun(ovr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_rot, input bit e_mux, input bit e_demux,
                         input bit e_busy, input bit e_fd, input int e_cnt, input bit e_ovr);
    chk({tag, ".rot"},   32'(rot),   32'(e_rot));
    chk({tag, ".mux"},   32'(mux),   32'(e_mux));
    chk({tag, ".demux"}, 32'(demux), 32'(e_demux));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".done"},  32'(fd),    32'(e_fd));
    chk({tag, ".cnt"},   32'(cnt),   32'(e_cnt));
    chk({tag, ".ovr"},   32'(ovr),   32'(e_ovr));
  endtask

  task automatic chk_out16(input string tag, input int e_rot, input bit e_mux, input bit e_demux,
                           input bit e_busy, input bit e_fd, input int e_cnt);
    chk({tag, ".rot"},   32'(rot2),   32'(e_rot));
    chk({tag, ".mux"},   32'(mux2),   32'(e_mux));
    chk({tag, ".demux"}, 32'(demux2), 32'(e_demux));
    chk({tag, ".busy"},  32'(busy2),  32'(e_busy));
    chk({tag, ".done"},  32'(fd2),    32'(e_fd));
    chk({tag, ".cnt"},   32'(cnt2),   32'(e_cnt));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sp = 1'b0; inv = 1'b0; en = 1'b0; clr = 1'b0;
    sp2 = 1'b0; en2 = 1'b0; inv2 = 1'b0; clr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; en = 1'b1; en2 = 1'b1;
    cyc();
    chk_out("idle0", 0, 0, 1, 0, 0, 0, 0);

    // Forward frame from a one-cycle start pulse
    sp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); sp = 1'b0;
      chk_out($sformatf("fwd%0d", i), i, i >= 4, i < 4, i != 0, i == 7, (i == 7) ? 1 : 0, 0);
    end
    cyc();
    chk_out("idle1", 0, 0, 1, 0, 0, 1, 0);

    // Inverse frame with inv_in toggling mid-frame, then a forward frame
    sp = 1'b1; inv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); sp = 1'b0; inv = ~inv;
      chk_out($sformatf("inv%0d", i), (8 - i) % 8, i >= 4, i < 4, i != 0, i == 7,
              (i == 7) ? 2 : 1, 0);
    end
    sp = 1'b1; inv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(); sp = 1'b0;
      chk_out($sformatf("fwd2_%0d", i), i, i >= 4, i < 4, i != 0, i == 7, (i == 7) ? 3 : 2, 0);
    end

    // Stall for three cycles while rotation shows 3
    sp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); sp = 1'b0;
      chk_out($sformatf("stl%0d", i), i, 0, 1, i != 0, 0, 3, 0);
    end
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk_out($sformatf("frz%0d", s), 3, 0, 1, 1, 0, 3, 0);
    end
    en = 1'b1;
    for (int i = 4; i < 8; i++) begin
      cyc();
      chk_out($sformatf("stl%0d", i), i, 1, 0, 1, i == 7, (i == 7) ? 4 : 3, 0);
    end

    // Three back-to-back frames; request only raised on the last/idle ticks
    sp = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        cyc();
        sp = (i >= 6) && !(f == 2 && i == 7);
        chk_out($sformatf("b2b%0d_%0d", f, i), i, i >= 4, i < 4, i != 0, i == 7,
                (i == 7) ? 5 + f : 4 + f, 0);
      end
    end

    // Start request at tick 3 raises sticky overrun without disturbing the frame
    sp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      sp = (i == 2);
      chk_out($sformatf("ovr%0d", i), i, i >= 4, i < 4, i != 0, i == 7,
              (i == 7) ? 8 : 7, i >= 3);
    end
    clr = 1'b1;
    cyc(); clr = 1'b0;
    chk_out("clr", 0, 0, 1, 0, 0, 8, 0);

    // Set and clear on the same edge: set wins
    sp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      sp = (i == 1); clr = (i == 1);
      chk_out($sformatf("win%0d", i), i, i >= 4, i < 4, i != 0, i == 7,
              (i == 7) ? 9 : 8, i >= 2);
    end
    clr = 1'b1;
    cyc(); clr = 1'b0;
    chk_out("clr2", 0, 0, 1, 0, 0, 9, 0);

    // Asynchronous reset at tick 5 aborts the frame
    sp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); sp = 1'b0;
      chk_out($sformatf("pre%0d", i), i, i >= 4, i < 4, i != 0, 0, 9, 0);
    end
    #2 rst = 1'b1;
    #1 chk_out("arst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); sp = 1'b0;
      chk_out($sformatf("post%0d", i), i, i >= 4, i < 4, i != 0, i == 7, (i == 7) ? 1 : 0, 0);
    end

    // 16-tick instance, step 2, load length 5
    sp2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(); sp2 = 1'b0;
      chk_out16($sformatf("f16_%0d", i), (2 * i) % 16, i >= 5, i < 5, i != 0, i == 15,
                (i == 15) ? 1 : 0);
    end
    cyc();
    chk_out16("f16_idle", 0, 0, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
